deadtime_gate_ctrl: RTL and testbench
=====================================

Name: deadtime_gate_ctrl

Overview:
- Downstream of the input glitch filter. Consumes its filtered 6-bit gate-command word, three half-bridge legs with a high/low pair each.
- Drives the gate outputs with guaranteed dead time between complementary switches of each leg.
- Latches a fault on shoot-through commands; the fault forces all gates off until cleared.

Parameters:
- N_LEGS, 3: number of half-bridge legs. Gate word width is 2*N_LEGS.
- DEAD_CYCLES, 50: minimum number of clk cycles with both switches of a leg off before either turns on. Must be >= 1.
- CNT_WIDTH, $clog2(DEAD_CYCLES+1): width of each per-leg dead-time counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, all legs are forced off and held in dead time.
- clear_fault  input  1  level request to clear the latched fault.
- in_gates  input  2*N_LEGS  filtered commands. Bit 2k = high side of leg k, bit 2k+1 = low side of leg k.
- out_gates  output  2*N_LEGS  gate drive, same bit mapping. Registered.
- fault  output  1  latched shoot-through fault.
- fault_leg  output  N_LEGS  sticky per-leg flag; bit k = leg k commanded 2'b11.
- leg_dead  output  N_LEGS  bit k high while leg k is in DEAD state (debug/monitor).

Behaviour:
- Reset (reset=0, async):
  - out_gates=0, fault=0, fault_leg=0, leg_dead=all ones.
  - Every leg enters DEAD with its counter at 0.
- Per-leg command decode: {in_gates[2k+1], in_gates[2k]}.
  - 00 = OFF_REQ, 01 = HI_REQ, 10 = LO_REQ, 11 = ILLEGAL.
- Per-leg FSM states: DEAD, IDLE, HI, LO. Outputs are decoded from registered state:
  - HI: high side = 1.
  - LO: low side = 1.
  - DEAD, IDLE: both 0.
- DEAD:
  - Counter increments each cycle.
  - On the cycle counter == DEAD_CYCLES-1, the next state is chosen by the command: HI_REQ -> HI, LO_REQ -> LO, OFF_REQ -> IDLE. The counter clears.
  - Result: both-off time is exactly DEAD_CYCLES cycles when a new request is already present.
- IDLE:
  - HI_REQ -> HI, LO_REQ -> LO, next cycle. Latency from in_gates to out_gates is 1 cycle.
  - OFF_REQ stays in IDLE.
- HI: any command other than HI_REQ -> DEAD, counter=0. This includes LO_REQ; a direct HI->LO transition is never allowed.
- LO: any command other than LO_REQ -> DEAD, counter=0.
- Fault detection:
  - ILLEGAL on any leg in any state, with fault=0 or 1, sets fault=1 and ORs the leg's bit into fault_leg. Legs flagged in the same cycle are all set.
  - While fault=1, all legs are forced to DEAD with counter held at 0, so out_gates=0 from the cycle after detection.
- Fault clear:
  - Clears when clear_fault=1 AND in_gates==0 AND no ILLEGAL present in the same cycle. Next cycle fault=0 and fault_leg=0.
  - Legs then start a full DEAD_CYCLES dead time from counter 0.
  - With clear_fault=1 while any input bit is set, the fault stays latched. Clear has no effect when fault=0.
- enable=0:
  - Takes precedence over FSM transitions: all legs go to DEAD, counter=0, out_gates=0 next cycle.
  - Fault detection remains active while enable=0.
  - On enable 0->1, each leg serves a full dead time before turning on.
- Simultaneous events in one cycle:
  - ILLEGAL + clear_fault: fault remains/sets.
  - enable=0 + ILLEGAL: fault is set.
- Reset asserted mid-dead-time or mid-conduction: outputs drop to 0 immediately, asynchronously.
- All legs are independent except the shared fault and enable.

Test Plan:
Bench uses DEAD_CYCLES=4.
1. Release reset, in_gates=6'b000001 held -> out_gates[0] rises 4 cycles after reset release (the post-reset DEAD expires), then stays 1; leg_dead[0] falls at the same edge.
2. Leg 0 in HI; in_gates 01 -> 10 -> out_gates[1:0]=00 for exactly 4 cycles, then 10. Never 11 on any cycle.
3. Leg 1 in IDLE, in_gates[3:2]=01 -> out_gates[3:2]=01 one cycle later. Then 01 -> 00 -> 01 with a 1-cycle gap -> 4 cycles off before re-enabling.
4. in_gates=6'b110001 -> next cycle fault=1, fault_leg=3'b100, out_gates=0.
   - clear_fault=1 with in_gates still 6'b110001 -> fault stays 1.
   - in_gates=0 with clear_fault=1 -> fault=0, fault_leg=0. Outputs held 0 for 4 cycles after clear.
5. Legs 0 and 2 both 11 in the same cycle -> fault_leg=3'b101. Later leg 1 goes 11 while faulted -> fault_leg=3'b111.
6. enable dropped for 1 cycle while leg 2 in LO -> out_gates[5:4]=00 next cycle. After enable returns, it stays 00 for 4 cycles, then 10.
   - reset pulsed mid-HI -> out_gates=0 asynchronously.

Source files
------------

// File: rtl/deadtime_gate_ctrl.sv
// deadtime_gate_ctrl: per-leg gate sequencer enforcing dead time, with latched shoot-through fault
module deadtime_gate_ctrl #(
    parameter int N_LEGS      = 3,
    parameter int DEAD_CYCLES = 50,
    parameter int CNT_WIDTH   = $clog2(DEAD_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_fault,
    input  logic [2*N_LEGS-1:0]   in_gates,
    output logic [2*N_LEGS-1:0]   out_gates,
    output logic                  fault,
    output logic [N_LEGS-1:0]     fault_leg,
    output logic [N_LEGS-1:0]     leg_dead
);
    localparam logic [1:0] DEAD = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] LO   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEAD_CYCLES - 1);

    logic [1:0]           state   [N_LEGS];
    logic [1:0]           state_n [N_LEGS];
    logic [CNT_WIDTH-1:0] cnt     [N_LEGS];
    logic [CNT_WIDTH-1:0] cnt_n   [N_LEGS];
    logic [N_LEGS-1:0]    illegal;
    logic [N_LEGS-1:0]    fault_leg_n;
    logic [N_LEGS-1:0]    leg_dead_n;
    logic [2*N_LEGS-1:0]  gates_n;
    logic                 fault_n;
    logic                 force_dead;

    // a leg commanding both switches on is a shoot-through request
    always_comb begin
        illegal = '0;
        for (int k = 0; k < N_LEGS; k++)
            illegal[k] = &in_gates[2*k +: 2];
    end

    // fault latches on any illegal leg; clears only with quiet inputs and a clear request
    always_comb begin
        fault_n     = fault;
        fault_leg_n = fault_leg;
        if (|illegal) begin
            fault_n     = 1'b1;
            fault_leg_n = fault_leg | illegal;
        end else if (fault && clear_fault && in_gates == '0) begin
            fault_n     = 1'b0;
            fault_leg_n = '0;
        end
    end

    // per-leg sequencer; a fault, a new illegal command or enable low parks every leg in dead time
    always_comb begin
        force_dead = !enable || fault || (|illegal);
        gates_n    = '0;
        leg_dead_n = '0;
        for (int k = 0; k < N_LEGS; k++) begin
            state_n[k] = DEAD;
            cnt_n[k]   = '0;
            if (!force_dead) begin
                case (state[k])
                    DEAD: begin
                        state_n[k] = (cnt[k] != LAST) ? DEAD :
                                     (in_gates[2*k +: 2] == 2'b01) ? HI :
                                     (in_gates[2*k +: 2] == 2'b10) ? LO : IDLE;
                        cnt_n[k]   = (cnt[k] != LAST) ? cnt[k] + 1'b1 : '0;
                    end
                    IDLE: state_n[k] = (in_gates[2*k +: 2] == 2'b01) ? HI :
                                       (in_gates[2*k +: 2] == 2'b10) ? LO : IDLE;
                    HI:   state_n[k] = (in_gates[2*k +: 2] == 2'b01) ? HI : DEAD;
                    default: state_n[k] = (in_gates[2*k +: 2] == 2'b10) ? LO : DEAD;
                endcase
            end
            gates_n[2*k]     = state_n[k] == HI;
            gates_n[2*k + 1] = state_n[k] == LO;
            leg_dead_n[k]    = state_n[k] == DEAD;
        end
    end

    // state and decoded outputs are registered together so the gate drive never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_LEGS; k++) begin
                state[k] <= DEAD;
                cnt[k]   <= '0;
            end
            out_gates <= '0;
            leg_dead  <= '1;
            fault     <= 1'b0;
            fault_leg <= '0;
        end else begin
            for (int k = 0; k < N_LEGS; k++) begin
                state[k] <= state_n[k];
                cnt[k]   <= cnt_n[k];
            end
            out_gates <= gates_n;
            leg_dead  <= leg_dead_n;
            fault     <= fault_n;
            fault_leg <= fault_leg_n;
        end
    end
endmodule

// File: tb/tb_deadtime_gate_ctrl.sv
// tb_deadtime_gate_ctrl: directed scoreboard bench for deadtime_gate_ctrl with DEAD_CYCLES=4
module tb_deadtime_gate_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       clear_fault = 1'b0;
    logic [5:0] in_gates = '0;
    logic [5:0] out_gates;
    logic       fault;
    logic [2:0] fault_leg;
    logic [2:0] leg_dead;

    typedef struct {
        string       nm;
        logic [12:0] e;
    } item_t;

    item_t sb[$];
    int    tests = 0;
    int    fails = 0;

    deadtime_gate_ctrl #(.N_LEGS(3), .DEAD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_fault(clear_fault),
        .in_gates(in_gates), .out_gates(out_gates), .fault(fault),
        .fault_leg(fault_leg), .leg_dead(leg_dead)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [5:0] g, input logic f,
                                       input logic [2:0] fl, input logic [2:0] ld);
        return {g, f, fl, ld};
    endfunction

    task automatic cmp(input string nm, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got gates=%b fault=%b fault_leg=%b leg_dead=%b, expected gates=%b fault=%b fault_leg=%b leg_dead=%b",
                     nm, act[12:7], act[6], act[5:3], act[2:0], exp[12:7], exp[6], exp[5:3], exp[2:0]);
        end
    endtask

    // drive inputs at the falling edge; expectation applies after the next rising edge
    task automatic step(input logic r, input logic [5:0] g, input logic en, input logic clr,
                        input string nm, input logic [12:0] e);
        @(negedge clk);
        reset       = r;
        in_gates    = g;
        enable      = en;
        clear_fault = clr;
        sb.push_back('{nm, e});
    endtask

    // monitor: one scoreboard entry per rising edge, sampled just after it
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                it = sb.pop_front();
                cmp(it.nm, pk(out_gates, fault, fault_leg, leg_dead), it.e);
            end
        end
    end

    initial begin
        step(0, 6'b000000, 1, 0, "reset_state", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t1_dead1", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t1_dead2", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t1_dead3", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t1_hi_on", pk(6'b000001, 0, 0, 0));
        step(1, 6'b000001, 1, 0, "t1_hi_hold", pk(6'b000001, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            step(1, 6'b000010, 1, 0, "t2_hi_to_lo_dead", pk(0, 0, 0, 3'b001));
        step(1, 6'b000010, 1, 0, "t2_lo_on", pk(6'b000010, 0, 0, 0));
        step(1, 6'b000110, 1, 0, "t3_idle_to_hi", pk(6'b000110, 0, 0, 0));
        step(1, 6'b000010, 1, 0, "t3_leg1_off", pk(6'b000010, 0, 0, 3'b010));
        for (int i = 0; i < 3; i++)
            step(1, 6'b000110, 1, 0, "t3_leg1_dead", pk(6'b000010, 0, 0, 3'b010));
        step(1, 6'b000110, 1, 0, "t3_leg1_reon", pk(6'b000110, 0, 0, 0));
        step(1, 6'b110001, 1, 0, "t4_fault_set", pk(0, 1, 3'b100, 3'b111));
        step(1, 6'b110001, 1, 1, "t4_clear_blocked", pk(0, 1, 3'b100, 3'b111));
        step(1, 6'b000000, 1, 1, "t4_clear", pk(0, 0, 0, 3'b111));
        for (int i = 0; i < 3; i++)
            step(1, 6'b000001, 1, 0, "t4_post_clear_dead", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t4_post_clear_on", pk(6'b000001, 0, 0, 0));
        step(1, 6'b110011, 1, 0, "t5_two_legs", pk(0, 1, 3'b101, 3'b111));
        step(1, 6'b001100, 1, 1, "t5_third_leg_with_clear", pk(0, 1, 3'b111, 3'b111));
        step(1, 6'b000000, 1, 1, "t5_clear", pk(0, 0, 0, 3'b111));
        for (int i = 0; i < 3; i++)
            step(1, 6'b100000, 1, 0, "t6_dead", pk(0, 0, 0, 3'b111));
        step(1, 6'b100000, 1, 0, "t6_lo_on", pk(6'b100000, 0, 0, 0));
        step(1, 6'b100000, 0, 0, "t6_enable_low", pk(0, 0, 0, 3'b111));
        for (int i = 0; i < 3; i++)
            step(1, 6'b100000, 1, 0, "t6_reenable_dead", pk(0, 0, 0, 3'b111));
        step(1, 6'b100000, 1, 0, "t6_reenable_on", pk(6'b100000, 0, 0, 0));
        step(1, 6'b000011, 0, 0, "t6_fault_while_disabled", pk(0, 1, 3'b001, 3'b111));
        step(1, 6'b000000, 1, 1, "t6_clear", pk(0, 0, 0, 3'b111));
        for (int i = 0; i < 3; i++)
            step(1, 6'b000001, 1, 0, "t6_dead2", pk(0, 0, 0, 3'b111));
        step(1, 6'b000001, 1, 0, "t6_hi_on", pk(6'b000001, 0, 0, 0));
        step(1, 6'b000001, 1, 0, "t6_hi_hold", pk(6'b000001, 0, 0, 0));
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1 cmp("async_reset", pk(out_gates, fault, fault_leg, leg_dead), pk(0, 0, 0, 3'b111));
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
